pipe_sched: RTL
===============

# pipe_sched

Central stage sequencer for the npc in-order pipeline (IF → ID → IS → WB). It owns the per-stage valid bits, latch enables, stalls and flushes, and the load/store wait on the shared data bus. It also applies the RAW interlock (no forwarding) and drains the pipe on ebreak before halting. It replaces the ad-hoc valid/finish chaining around the stage registers. It does not arbitrate the bus itself.

## Interface
Parameters:
- `CNT_W`, 64: width of the retired-instruction counter.
- `STALL_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_valid`  in  1  IF holds a fetched instruction (pulse or level).
- `fetch_accept`  out  1  instruction moves IF → ID this cycle.
- `id_rs1`, `id_rs2`  in  5  ID source register indices.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction reads that source.
- `id_rd`, `id_rf_wen`  in  5 / 1  ID destination register and write enable.
- `is_mem`  in  1  IS instruction is a load or store.
- `is_redirect`  in  1  IS instruction changes PC (taken branch or jump).
- `is_ebreak`  in  1  IS instruction is ebreak.
- `mem_finish`  in  1  data-bus transaction complete (one-cycle pulse).
- `mem_start`  out  1  one-cycle pulse that launches the IS memory access.
- `id_en`, `is_en`, `wb_en`  out  1  load enables for the ID, IS and WB pipeline registers.
- `id_valid`, `is_valid`, `wb_valid`  out  1  stage holds a live instruction.
- `redirect_take`  out  1  one-cycle pulse telling IF to refetch from the jump target.
- `commit`  out  1  WB retires an instruction; gates the register-file write.
- `halted`  out  1  ebreak retired; held until reset.
- `instret`  out  `CNT_W`  count of retired instructions.
- `stall_cnt`  out  `STALL_W`  count of cycles in which ID held a valid instruction but did not advance.

## Operation
- **Top FSM.**
  - RUN → DRAIN when IS completes with `is_ebreak`.
  - DRAIN → HALT on the cycle that ebreak commits.
  - HALT is terminal.
  - `fetch_accept`, `id_en` and `is_en` are 0 in DRAIN and HALT.
- **IS memory FSM.**
  - IDLE: when `is_valid & is_mem`, pulse `mem_start` and go to WAIT.
  - WAIT: on `mem_finish`, IS is done; return to IDLE.
  - A non-memory IS instruction is done in the cycle it is valid.
  - `mem_finish` is ignored in IDLE.
- **Stage advance.**
  - is_done = `is_valid` & (!`is_mem` | (WAIT & `mem_finish`)).
  - is_ready = !`is_valid` | is_done.
  - WB is always ready: `wb_en` = is_done; `wb_valid` is set next cycle from is_done.
  - id_go = `id_valid` & !hazard & is_ready & RUN & !flush. `is_en` = id_go; on !id_go with is_done, `is_valid` clears.
  - id_ready = !`id_valid` | id_go.
  - `fetch_accept` = `fetch_valid` & id_ready & RUN & !flush. `id_en` = `fetch_accept`.
- **Hazard (RAW).** Stall ID when a used source index is nonzero and equals the rd of a valid IS or WB instruction with rf_wen. x0 never hazards. `id_rd`/`id_rf_wen` are captured into IS/WB shadow registers on the same enables.
- **Flush.**
  - Flush occurs when is_done & `is_redirect` & !`is_ebreak`.
  - The same cycle: `redirect_take` = 1, `id_valid` clears, and `fetch_accept` = 0, so any fetch presented that cycle is dropped.
  - ebreak takes priority over redirect.
- **Commit.**
  - `commit` = `wb_valid`.
  - `instret` increments on `commit`.
  - `stall_cnt` increments when `id_valid` & !id_go in RUN. Both counters wrap modulo 2^width.

## Timing
- Reset values: all outputs 0, both counters 0, FSMs in RUN / IDLE, all valid bits 0.
- Reset mid-transaction abandons the WAIT state. `mem_start` is not re-issued, and the bus side is reset together with this block.
- Non-memory instruction latency: accepted at cycle t → ID t+1 → IS t+2 → `commit` at t+3.
- A load or store adds the cycles from `mem_start` to `mem_finish`; `mem_finish` in the same cycle as `mem_start` is not legal.
- Sustained throughput is 1 instruction per cycle without hazards or memory operations.
- A RAW hazard on an IS producer costs at most 2 bubble cycles.
- `mem_start` is combinational from state. The other pulse outputs are registered-state derived and never last more than one cycle.
- In HALT, `commit` is 0 and `halted` = 1.

## Structure
- Shared package `npc_pipe_pkg` holds:
  - top FSM enum (RUN, DRAIN, HALT);
  - memory FSM enum (IDLE, WAIT);
  - register-index width constant `REG_IDX_W` = 5.
- Sub-module `raw_check`: combinational comparator producing the hazard signal from the ID sources and the IS/WB destination shadows.
- Everything else sits in `pipe_sched`.

## Test plan
- **Straight-line code:** 4 independent ALU instructions, `fetch_valid` held high → `commit` high on cycles 3–6; `instret` = 4; `stall_cnt` = 0.
- **Load:** IS holds a load; `mem_finish` arrives 5 cycles after `mem_start` → ID stays held; `stall_cnt` += 5; `commit` follows 1 cycle after `mem_finish`.
- **RAW and x0:**
  - `addi x5` followed by `add x6,x5,x5` → 2 bubbles, `stall_cnt` = 2.
  - Same sequence with rd = x0 → 0 bubbles.
- **Redirect:** jal completes in IS while `fetch_valid` = 1 → `redirect_take` pulses once; `id_valid` clears; that fetch is not counted; `instret` counts only the jal plus instructions at the target.
- **Ebreak:** ebreak with `is_redirect` = 1 → no `redirect_take`; `fetch_accept` = 0 thereafter; `halted` = 1 one cycle after its commit; further `fetch_valid` is ignored.
- **Reset mid-WAIT:** `rst` asserted during WAIT → next cycle all valid bits 0, counters 0; no `mem_start` until a new memory instruction reaches IS.

Source files
------------

// File: rtl/npc_pipe_pkg.sv
// Shared types for the npc pipeline sequencer: top/memory FSM states and
// register-index width.
package npc_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } top_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/raw_check.sv
// RAW interlock: flags an ID source that matches a pending IS/WB destination.
module raw_check
    import npc_pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 is_valid,
    input  logic                 is_wen,
    input  logic [REG_IDX_W-1:0] is_rd,
    input  logic                 wb_valid,
    input  logic                 wb_wen,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a producer targeting it never blocks a reader
    assign rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                     ((is_valid && is_wen && (is_rd == id_rs1)) ||
                      (wb_valid && wb_wen && (wb_rd == id_rs1)));
    assign rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                     ((is_valid && is_wen && (is_rd == id_rs2)) ||
                      (wb_valid && wb_wen && (wb_rd == id_rs2)));
    assign hazard  = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipe_sched.sv
// Stage sequencer for the IF->ID->IS->WB pipe: valid bits, enables, RAW stall,
// redirect flush, load/store wait and ebreak drain/halt.
module pipe_sched
    import npc_pipe_pkg::*;
#(
    parameter int CNT_W   = 64,
    parameter int STALL_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    output logic                 fetch_accept,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_rf_wen,
    input  logic                 is_mem,
    input  logic                 is_redirect,
    input  logic                 is_ebreak,
    input  logic                 mem_finish,
    output logic                 mem_start,
    output logic                 id_en,
    output logic                 is_en,
    output logic                 wb_en,
    output logic                 id_valid,
    output logic                 is_valid,
    output logic                 wb_valid,
    output logic                 redirect_take,
    output logic                 commit,
    output logic                 halted,
    output logic [CNT_W-1:0]     instret,
    output logic [STALL_W-1:0]   stall_cnt
);

    top_state_e top_q, top_d;
    mem_state_e mem_q, mem_d;
    logic id_valid_q, id_valid_d;
    logic is_valid_q, is_valid_d;
    logic wb_valid_q, wb_valid_d;
    logic halted_q, halted_d;
    logic [REG_IDX_W-1:0] is_rd_q, is_rd_d, wb_rd_q, wb_rd_d;
    logic is_wen_q, is_wen_d, wb_wen_q, wb_wen_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic hazard, run, is_done, is_ready, flush, id_go, id_ready;

    raw_check u_raw_check (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .is_valid   (is_valid_q),
        .is_wen     (is_wen_q),
        .is_rd      (is_rd_q),
        .wb_valid   (wb_valid_q),
        .wb_wen     (wb_wen_q),
        .wb_rd      (wb_rd_q),
        .hazard     (hazard)
    );

    always_comb begin
        run      = (top_q == RUN);
        is_done  = is_valid_q && (!is_mem || ((mem_q == WAIT) && mem_finish));
        is_ready = !is_valid_q || is_done;
        // ebreak outranks redirect: it drains instead of refetching
        flush    = is_done && is_redirect && !is_ebreak;
        id_go    = id_valid_q && !hazard && is_ready && run && !flush;
        id_ready = !id_valid_q || id_go;

        fetch_accept  = fetch_valid && id_ready && run && !flush;
        id_en         = fetch_accept;
        is_en         = id_go;
        wb_en         = is_done;
        mem_start     = is_valid_q && is_mem && (mem_q == IDLE);
        redirect_take = flush;
        commit        = wb_valid_q && (top_q != HALT);
        id_valid      = id_valid_q;
        is_valid      = is_valid_q;
        wb_valid      = wb_valid_q;
        halted        = halted_q;
        instret       = instret_q;
        stall_cnt     = stall_q;

        id_valid_d = id_valid_q;
        if (flush)             id_valid_d = 1'b0;
        else if (fetch_accept) id_valid_d = 1'b1;
        else if (id_go)        id_valid_d = 1'b0;

        is_valid_d = is_valid_q;
        if (id_go)        is_valid_d = 1'b1;
        else if (is_done) is_valid_d = 1'b0;
        wb_valid_d = is_done;

        is_rd_d  = id_go   ? id_rd     : is_rd_q;
        is_wen_d = id_go   ? id_rf_wen : is_wen_q;
        wb_rd_d  = is_done ? is_rd_q   : wb_rd_q;
        wb_wen_d = is_done ? is_wen_q  : wb_wen_q;

        mem_d = mem_q;
        case (mem_q)
            IDLE:    if (is_valid_q && is_mem) mem_d = WAIT;
            WAIT:    if (mem_finish)           mem_d = IDLE;
            default: mem_d = IDLE;
        endcase

        top_d    = top_q;
        halted_d = halted_q;
        case (top_q)
            RUN:   if (is_done && is_ebreak) top_d = DRAIN;
            // the first commit seen in DRAIN is the ebreak itself
            DRAIN: if (commit) begin
                top_d    = HALT;
                halted_d = 1'b1;
            end
            HALT:    top_d = HALT;
            default: top_d = RUN;
        endcase

        instret_d = commit ? instret_q + CNT_W'(1) : instret_q;
        stall_d   = (id_valid_q && !id_go && run) ? stall_q + STALL_W'(1) : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q      <= RUN;
            mem_q      <= IDLE;
            id_valid_q <= 1'b0;
            is_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            is_rd_q    <= '0;
            is_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_wen_q   <= 1'b0;
            instret_q  <= '0;
            stall_q    <= '0;
        end else begin
            top_q      <= top_d;
            mem_q      <= mem_d;
            id_valid_q <= id_valid_d;
            is_valid_q <= is_valid_d;
            wb_valid_q <= wb_valid_d;
            halted_q   <= halted_d;
            is_rd_q    <= is_rd_d;
            is_wen_q   <= is_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            instret_q  <= instret_d;
            stall_q    <= stall_d;
        end
    end

endmodule
